bip_ctrl: RTL and testbench

- Multi-cycle control sequencer for the accumulator CPU. It drives fetch, decode and execute around the combinational instruction decoder, the program ROM and the data RAM.
- Owns the program counter and instruction register.
- Gates the decoder's raw control outputs (wr_acc, wr_ram, rd_ram, wr_pc) into single-cycle strobes.
- Handles start, halt and the cycle counter used by the debug unit.

---
 rtl/bip_ctrl.sv | 114 +++++++++++
 tb/tb_bip_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_ctrl.sv
// rtl/bip_ctrl.sv - fetch/decode/execute sequencer for the accumulator CPU.
// Optional single-step WAIT state is built when BIP_CTRL_STEP_EN is defined.
module bip_ctrl #(
  parameter int PC_W      = 11,
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11,
  parameter int CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
`ifdef BIP_CTRL_STEP_EN
  input  logic                          step,
  output logic                          step_wait,
`endif
  output logic [PC_W-1:0]               prog_addr,
  input  logic [OPCODE_W+OPERAND_W-1:0] prog_data,
  output logic [OPCODE_W-1:0]           opcode,
  output logic [OPERAND_W-1:0]          operand,
  input  logic                          dec_wr_pc,
  input  logic                          dec_wr_acc,
  input  logic                          dec_wr_ram,
  input  logic                          dec_rd_ram,
  output logic                          wr_acc,
  output logic                          wr_ram,
  output logic                          rd_ram,
  output logic                          busy,
  output logic                          halted,
  output logic [CNT_W-1:0]              cycle_cnt
);

  localparam int IR_W = OPCODE_W + OPERAND_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_WAIT
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [IR_W-1:0]   ir;
  logic              done;

  assign prog_addr = pc;
  assign opcode    = ir[IR_W-1 -: OPCODE_W];
  assign operand   = ir[OPERAND_W-1:0];

  // Decoder outputs are only looked at in EXEC/WB, so X elsewhere is harmless.
  assign done   = (state == S_EXEC && !dec_rd_ram) || (state == S_WB);
  assign rd_ram = (state == S_EXEC) && dec_rd_ram;
  assign wr_ram = (state == S_EXEC) && dec_wr_ram;
  assign wr_acc = done && dec_wr_acc;
  assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXEC)  || (state == S_WB);
  assign halted = (state == S_HALT);
`ifdef BIP_CTRL_STEP_EN
  assign step_wait = (state == S_WAIT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      cycle_cnt <= '0;
    end else begin
      if (busy && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;

      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc        <= '0;
            cycle_cnt <= '0;
            state     <= S_FETCH;
          end
        end
`ifdef BIP_CTRL_STEP_EN
        S_WAIT: begin
          if (start) begin
            pc        <= '0;
            cycle_cnt <= '0;
            state     <= S_FETCH;
          end else if (step) begin
            state <= S_FETCH;
          end
        end
`endif
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= prog_data;
          state <= S_EXEC;
        end
        S_EXEC:   if (dec_rd_ram) state <= S_WB;
        S_WB:     ;
        default:  state <= S_IDLE;
      endcase

      // Instruction completion: HLT is the only opcode that leaves wr_pc low.
      if (done) begin
        if (dec_wr_pc) begin
          pc <= pc + 1'b1;
`ifdef BIP_CTRL_STEP_EN
          state <= S_WAIT;
`else
          state <= S_FETCH;
`endif
        end else begin
          state <= S_HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_bip_ctrl.sv
// tb/tb_bip_ctrl.sv - directed self-checking bench for bip_ctrl.
// A second small-PC instance covers the wrap of the program counter.
module tb_bip_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, start_s, dec_force;
  logic [15:0] rom   [0:2047];
  logic [15:0] rom_s [0:7];

  logic [10:0] prog_addr;
  logic [15:0] prog_data;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        dec_wr_pc, dec_wr_acc, dec_wr_ram, dec_rd_ram;
  logic        wr_acc, wr_ram, rd_ram, busy, halted;
  logic [31:0] cycle_cnt;

  logic [2:0]  prog_addr_s;
  logic [15:0] prog_data_s;
  logic [4:0]  opcode_s;
  logic [10:0] operand_s;
  logic        dwp_s, dwa_s, dwr_s, drr_s;
  logic        wr_acc_s, wr_ram_s, rd_ram_s, busy_s, halted_s;
  logic [31:0] cycle_cnt_s;
`ifdef BIP_CTRL_STEP_EN
  logic        step, step_wait, step_s, step_wait_s;
`endif

  int checks = 0;
  int failures = 0;
  int n_acc, n_rd, n_wr, acc_after_rd, first_acc, halt_cyc;
  logic [10:0] wr_operand;

  always #5 clk = ~clk;

  // Reference decoder: {wr_pc, wr_acc, wr_ram, rd_ram}
  function automatic logic [3:0] decode(input logic [4:0] op);
    case (op)
      5'd0:             return 4'b0000;
      5'd1, 5'd2, 5'd3: return 4'b1100;
      5'd4, 5'd5, 5'd6: return 4'b1101;
      5'd7:             return 4'b1010;
      default:          return 4'b1000;
    endcase
  endfunction

  assign {dec_wr_pc, dec_wr_acc, dec_wr_ram, dec_rd_ram} = dec_force ? 4'b1111 : decode(opcode);
  assign {dwp_s, dwa_s, dwr_s, drr_s} = decode(opcode_s);

  always @(posedge clk) prog_data   <= rom[prog_addr];
  always @(posedge clk) prog_data_s <= rom_s[prog_addr_s];

  bip_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef BIP_CTRL_STEP_EN
    .step(step), .step_wait(step_wait),
`endif
    .prog_addr(prog_addr), .prog_data(prog_data), .opcode(opcode), .operand(operand),
    .dec_wr_pc(dec_wr_pc), .dec_wr_acc(dec_wr_acc), .dec_wr_ram(dec_wr_ram),
    .dec_rd_ram(dec_rd_ram), .wr_acc(wr_acc), .wr_ram(wr_ram), .rd_ram(rd_ram),
    .busy(busy), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  bip_ctrl #(.PC_W(3)) dut_s (
    .clk(clk), .reset(reset), .start(start_s),
`ifdef BIP_CTRL_STEP_EN
    .step(step_s), .step_wait(step_wait_s),
`endif
    .prog_addr(prog_addr_s), .prog_data(prog_data_s), .opcode(opcode_s), .operand(operand_s),
    .dec_wr_pc(dwp_s), .dec_wr_acc(dwa_s), .dec_wr_ram(dwr_s),
    .dec_rd_ram(drr_s), .wr_acc(wr_acc_s), .wr_ram(wr_ram_s), .rd_ram(rd_ram_s),
    .busy(busy_s), .halted(halted_s), .cycle_cnt(cycle_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pulses start, then records strobe activity until halted or limit expires.
  task automatic run_prog(input int limit);
    logic prev_rd;
    n_acc = 0; n_rd = 0; n_wr = 0; acc_after_rd = 0; first_acc = 0;
    halt_cyc = 0; prev_rd = 1'b0; wr_operand = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (halted) begin
        halt_cyc = c;
        break;
      end
      if (wr_acc) begin
        n_acc++;
        if (first_acc == 0) first_acc = c;
        if (prev_rd) acc_after_rd++;
      end
      if (rd_ram) n_rd++;
      if (wr_ram) begin
        n_wr++;
        wr_operand = operand;
      end
      prev_rd = rd_ram;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start_s = 1'b0; dec_force = 1'b0;
`ifdef BIP_CTRL_STEP_EN
    step = 1'b0; step_s = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rom_s[i] = {5'd1, 11'd0};

    do_reset();
    check("rst_pc", prog_addr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", cycle_cnt, 0);
    dec_force = 1'b1;
    #1;
    check("idle_strobes_forced", {wr_acc, wr_ram, rd_ram}, 0);
    dec_force = 1'b0;

`ifndef BIP_CTRL_STEP_EN
    // LDI 5 ; HLT
    rom[0] = {5'd1, 11'd5};
    rom[1] = 16'h0000;
    run_prog(50);
    check("ldi_acc_count", n_acc, 1);
    check("ldi_acc_cycle", first_acc, 3);
    check("ldi_halt_cycle", halt_cyc, 7);
    check("ldi_pc", prog_addr, 1);
    check("ldi_cnt", cycle_cnt, 6);
    tick(); tick(); tick();
    check("halt_cnt_hold", cycle_cnt, 6);
    check("halt_hold", halted, 1);
    dec_force = 1'b1;
    #1;
    check("halt_strobes_forced", {wr_acc, wr_ram, rd_ram}, 0);
    dec_force = 1'b0;

    // LD 7 ; ADD 8 ; STO 9 ; HLT
    rom[0] = {5'd4, 11'd7};
    rom[1] = {5'd5, 11'd8};
    rom[2] = {5'd7, 11'd9};
    rom[3] = 16'h0000;
    run_prog(80);
    check("mem_rd_count", n_rd, 2);
    check("mem_acc_count", n_acc, 2);
    check("mem_rd_then_acc", acc_after_rd, 2);
    check("mem_first_acc", first_acc, 4);
    check("mem_wr_count", n_wr, 1);
    check("mem_wr_operand", wr_operand, 9);
    check("mem_cnt", cycle_cnt, 14);
    check("mem_pc", prog_addr, 3);

    // Unknown opcode executes as NOP
    rom[0] = {5'b11111, 11'h7ff};
    rom[1] = 16'h0000;
    run_prog(50);
    check("nop_strobes", n_acc + n_rd + n_wr, 0);
    check("nop_pc", prog_addr, 1);
    check("nop_halted", halted, 1);
    check("nop_cnt", cycle_cnt, 6);

    // PC wrap on the 3-bit instance, every instruction takes 3 cycles
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if ((c % 3) == 1 && (c - 1) / 3 >= 6)
        check($sformatf("wrap_pc_k%0d", (c - 1) / 3), prog_addr_s, ((c - 1) / 3) % 8);
      tick();
    end

    // LDI ; LDI ; ADD 3 ; HLT -- start while busy, then reset in ADD's WB
    rom[0] = {5'd1, 11'd1};
    rom[1] = {5'd1, 11'd2};
    rom[2] = {5'd5, 11'd3};
    rom[3] = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_pc", prog_addr, 2);
    check("busy_start_busy", busy, 1);
    check("add_exec_rd", rd_ram, 1);
    tick();
    check("add_wb_acc", wr_acc, 1);
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_halted", halted, 0);
    check("midrst_acc", wr_acc, 0);
    check("midrst_pc", prog_addr, 0);
    check("midrst_cnt", cycle_cnt, 0);
    reset = 1'b0;
    tick();
    check("postrst_idle", busy, 0);
`else
    // LDI 1 ; LDI 2 ; HLT in single-step mode
    rom[0] = {5'd1, 11'd1};
    rom[1] = {5'd1, 11'd2};
    rom[2] = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("step1_wait", step_wait, 1);
    check("step1_busy", busy, 0);
    check("step1_pc", prog_addr, 1);
    for (int i = 0; i < 5; i++) tick();
    check("step1_still_wait", step_wait, 1);
    check("step1_cnt_hold", cycle_cnt, 3);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step1_resume", busy, 1);
    tick(); tick(); tick();
    check("step2_wait", step_wait, 1);
    check("step2_pc", prog_addr, 2);
    for (int i = 0; i < 4; i++) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(); tick(); tick();
    check("step_halted", halted, 1);
    check("step_no_wait", step_wait, 0);
    check("step_cnt", cycle_cnt, 9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
